sat_accum_seq: RTL and testbench

- Multi-cycle accumulation sequencer that feeds the 16-bit saturating adder/subtractor stage.
- Accepts a start command with a sample count and add/sub mode, then streams that many signed 16-bit samples through a valid/ready handshake.
- Each accepted sample is folded into a running accumulator with saturating arithmetic; records sticky overflow.
- Presents the final result plus Z/N/V flags to the writeback side through a valid/ready handshake.

---
 rtl/sat_accum_seq.sv | 157 +++++++++++++++
 tb/tb_sat_accum_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sat_accum_seq.sv
// Multi-cycle saturating accumulation sequencer: start command, streamed samples, flagged result.
// Optional SAT_ACCUM_ABORT_EN adds an abort input that ends ACCUM early with the current result.
module sat_accum_seq #(
  parameter int unsigned CNT_W    = 8,
  parameter logic [15:0] INIT_VAL = 16'h0000
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SAT_ACCUM_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             sub,
  input  logic [CNT_W-1:0] count,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [15:0]      out_data,
  output logic [2:0]       out_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                sub_q, sub_d;
  logic                v_q, v_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [2:0]          out_flags_q, out_flags_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic                xfer;
  logic                abort_act;
  logic [DATA_W-1:0]   opb;
  logic [DATA_W:0]     sum_full;
  logic                c15;
  logic                ovf;
  logic [DATA_W-1:0]   sat_res;

`ifdef SAT_ACCUM_ABORT_EN
  assign abort_act = abort && (state_q == ACCUM);
`else
  assign abort_act = 1'b0;
`endif

  assign xfer = in_valid && in_ready_q;

  // Adder stage: A + (sub ? ~B + 1 : B), saturating on the sign of A
  always_comb begin
    opb      = sub_q ? ~in_data : in_data;
    sum_full = {1'b0, acc_q} + {1'b0, opb} + (DATA_W+1)'(sub_q);
    c15      = acc_q[15] ^ opb[15] ^ sum_full[15];
    ovf      = c15 ^ sum_full[16];
    sat_res  = ovf ? (acc_q[15] ? 16'h8000 : 16'h7FFF) : sum_full[DATA_W-1:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = (count == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (abort_act)                          state_d = DONE;
        else if (xfer && rem_q == CNT_W'(1))    state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    acc_d       = acc_q;
    rem_d       = rem_q;
    sub_d       = sub_q;
    v_d         = v_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = INIT_VAL;
          v_d   = 1'b0;
          sub_d = sub;
          rem_d = count;
        end
      end
      ACCUM: begin
        if (abort_act) begin
          rem_d = '0;
        end else if (xfer) begin
          acc_d = sat_res;
          v_d   = v_q | ovf;
          rem_d = rem_q - CNT_W'(1);
        end
      end
      default: ;
    endcase
    // Result is captured once, on the way into DONE, and then held
    if (state_d == DONE && state_q != DONE) begin
      out_data_d  = acc_d;
      out_flags_d = {acc_d == '0, acc_d[15], v_d};
    end
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d == ACCUM);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= INIT_VAL;
      rem_q       <= '0;
      sub_q       <= 1'b0;
      v_q         <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      sub_q       <= sub_d;
      v_q         <= v_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_flags = out_flags_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sat_accum_seq.sv
// Self-checking bench for sat_accum_seq: directed plan cases plus randomized transactions
// checked against an integer-arithmetic saturating reference model.
module tb_sat_accum_seq;

  localparam int unsigned CNT_W    = 8;
  localparam logic [15:0] INIT_VAL = 16'h0000;

  logic             clk;
  logic             rst_n;
  logic             abort;
  logic             start;
  logic             sub;
  logic [CNT_W-1:0] count;
  logic [15:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      out_data;
  logic [2:0]       out_flags;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] smp [0:255];

  sat_accum_seq #(.CNT_W(CNT_W), .INIT_VAL(INIT_VAL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef SAT_ACCUM_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .sub       (sub),
    .count     (count),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: fold samples with true integer arithmetic, clamp to the 16-bit signed range
  task automatic model(input bit s, input int n, output logic [15:0] ed, output logic [2:0] ef);
    int a;
    int r;
    bit v;
    a = int'($signed(INIT_VAL));
    v = 1'b0;
    for (int k = 0; k < n; k++) begin
      r = s ? a - int'($signed(smp[k])) : a + int'($signed(smp[k]));
      if (r > 32767) begin r = 32767; v = 1'b1; end
      else if (r < -32768) begin r = -32768; v = 1'b1; end
      a = r;
    end
    ed = 16'(a);
    ef = {ed == 16'h0000, ed[15], v};
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_data"},  32'(out_data), 32'h0);
    chk({tag, "_flags"}, 32'(out_flags), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  // gap_mode: 0 back-to-back, 1 toggle every other cycle, 2 random
  task automatic run_txn(input bit s, input int n, input int gap_mode, input int stall);
    logic [15:0] ed;
    logic [2:0]  ef;
    int i;
    int cyc;
    model(s, n, ed, ef);
    start = 1'b1;
    sub   = s;
    count = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    sub   = 1'($urandom);
    count = CNT_W'($urandom);
    chk("busy_after_start", 32'(busy), 32'h1);
    i = 0;
    for (cyc = 0; cyc < 8 * n + 8 && i < n; cyc++) begin
      chk("in_ready_accum", 32'(in_ready), 32'h1);
      case (gap_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = cyc[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? smp[i] : 16'($urandom);
      start   = ($urandom_range(0, 5) == 0);
      count   = CNT_W'($urandom);
      @(posedge clk); #1;
      if (in_valid) i++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("stream_len", 32'(i), 32'(n));
    chk("out_valid_rise", 32'(out_valid), 32'h1);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      start    = 1'b1;
      chk("stall_data",  32'(out_data), 32'(ed));
      chk("stall_flags", 32'(out_flags), 32'(ef));
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("done_in_ready", 32'(in_ready), 32'h0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("done_data",  32'(out_data), 32'(ed));
    chk("done_flags", 32'(out_flags), 32'(ef));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_valid", 32'(out_valid), 32'h0);
    chk("idle_busy",  32'(busy), 32'h0);
    chk("idle_hold_data",  32'(out_data), 32'(ed));
    chk("idle_hold_flags", 32'(out_flags), 32'(ef));
  endtask

  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    start     = 1'b0;
    sub       = 1'b0;
    count     = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #22;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    smp[0] = 16'h0001; smp[1] = 16'h0002; smp[2] = 16'h0003;
    run_txn(1'b0, 3, 0, 0);
    smp[0] = 16'h7000; smp[1] = 16'h7000;
    run_txn(1'b0, 2, 0, 1);
    smp[0] = 16'h7FFF; smp[1] = 16'h7FFF; smp[2] = 16'h0001;
    run_txn(1'b1, 3, 0, 0);
    smp[0] = 16'h1234; smp[1] = 16'hF000; smp[2] = 16'h0100; smp[3] = 16'h8000;
    run_txn(1'b1, 4, 1, 5);
    run_txn(1'b0, 0, 0, 2);
    smp[0] = 16'h8000;
    run_txn(1'b1, 1, 0, 0);

    // Reset in the middle of ACCUM after one of four samples
    smp[0] = 16'h0101; smp[1] = 16'h0202;
    run_txn(1'b0, 2, 0, 0);
    start = 1'b1; sub = 1'b0; count = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_reset");
    smp[0] = 16'hFFFF;
    run_txn(1'b0, 1, 0, 0);

`ifdef SAT_ACCUM_ABORT_EN
    // Abort after two of four samples; the concurrent sample is dropped
    start = 1'b1; sub = 1'b0; count = CNT_W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0010;
    @(posedge clk); #1;
    in_data = 16'h0020;
    @(posedge clk); #1;
    abort = 1'b1; in_data = 16'h1000;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_valid", 32'(out_valid), 32'h1);
    chk("abort_data",  32'(out_data), 32'h0030);
    chk("abort_flags", 32'(out_flags), 32'h0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("abort_idle", 32'(busy), 32'h0);
`endif

    // Maximum count with random full-range samples
    for (int k = 0; k < 255; k++) smp[k] = 16'($urandom);
    run_txn(1'($urandom), 255, 0, 1);

    for (int t = 0; t < 30; t++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       smp[k] = 16'h7FFF - 16'($urandom_range(0, 3));
          1:       smp[k] = 16'h8000 + 16'($urandom_range(0, 3));
          2:       smp[k] = 16'($urandom_range(0, 15));
          default: smp[k] = 16'($urandom);
        endcase
      end
      run_txn(1'($urandom), n, 2, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
